// File: rtl/ls_sequencer.sv
// D-form load/store controller; done comes MEM_LAT+2 (store) or MEM_LAT+3 (load) cycles after accept, +1 for update forms.
// Only one instruction is in flight, so instr_ready is high in IDLE only. Define LS_UPDATE_FORM_EN to enable stwu/lwzu.
module ls_sequencer #(
    parameter int MEM_LAT = 1,
    parameter int CNT_W   = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_instr_valid,
    input  logic [31:0]      i_instr,
    output logic             o_instr_ready,
    output logic [3:0]       o_alu_op,
    output logic [4:0]       o_read_reg_1,
    output logic [4:0]       o_read_reg_2,
    output logic [4:0]       o_write_reg,
    output logic [31:0]      o_immediate,
    output logic             o_reg_write,
    output logic             o_mem_read,
    output logic             o_mem_write,
    output logic             o_wb_sel,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_illegal,
    output logic [CNT_W-1:0] o_retired
);

    localparam int MC_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    generate
        if (MEM_LAT < 1) begin : g_bad_mem_lat
            $error("ls_sequencer: MEM_LAT must be >= 1");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ADDR = 3'd1,
        S_MEM  = 3'd2,
        S_WB   = 3'd3,
        S_DONE = 3'd4,
        S_ERR  = 3'd5
`ifdef LS_UPDATE_FORM_EN
        , S_UPD = 3'd6
`endif
    } state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic [31:0]       r_instr;
    logic [MC_W-1:0]   r_mem_cnt;
    logic [CNT_W-1:0]  r_retired;

    logic [5:0]        w_in_op;
    logic [4:0]        w_in_ra;
    logic [4:0]        w_in_rt;
    logic              w_in_legal;
    logic              w_accept;
    logic [5:0]        w_op;
    logic              w_is_store;
    logic              w_mem_last;

    assign w_in_op = i_instr[31:26];
    assign w_in_rt = i_instr[25:21];
    assign w_in_ra = i_instr[20:16];

    // Legality is judged on the incoming word so an illegal one never reaches ADDR.
`ifdef LS_UPDATE_FORM_EN
    assign w_in_legal = (w_in_op == 6'd36) || (w_in_op == 6'd32)
                     || ((w_in_op == 6'd37) && (w_in_ra != 5'd0))
                     || ((w_in_op == 6'd33) && (w_in_ra != 5'd0) && (w_in_ra != w_in_rt));
`else
    assign w_in_legal = (w_in_op == 6'd36) || (w_in_op == 6'd32);
`endif

    assign w_accept = i_instr_valid && (r_state == S_IDLE);
    assign w_op     = r_instr[31:26];

`ifdef LS_UPDATE_FORM_EN
    logic w_is_upd;
    assign w_is_store = (w_op == 6'd36) || (w_op == 6'd37);
    assign w_is_upd   = (w_op == 6'd37) || (w_op == 6'd33);
`else
    assign w_is_store = (w_op == 6'd36);
`endif

    assign w_mem_last = (r_mem_cnt == MC_W'(MEM_LAT - 1));

    assign o_read_reg_1  = r_instr[20:16];
    assign o_read_reg_2  = r_instr[25:21];
    assign o_immediate   = {{16{r_instr[15]}}, r_instr[15:0]};
    assign o_instr_ready = (r_state == S_IDLE);
    assign o_busy        = (r_state != S_IDLE);
    assign o_retired     = r_retired;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= S_IDLE;
            r_instr   <= '0;
            r_mem_cnt <= '0;
            r_retired <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_accept) begin
                r_instr <= i_instr;
            end
            if ((r_state == S_MEM) && !w_mem_last) begin
                r_mem_cnt <= r_mem_cnt + 1'b1;
            end else begin
                r_mem_cnt <= '0;
            end
            if (r_state == S_DONE) begin
                r_retired <= r_retired + 1'b1;
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        o_alu_op     = 4'b0000;
        o_reg_write  = 1'b0;
        o_mem_read   = 1'b0;
        o_mem_write  = 1'b0;
        o_wb_sel     = 1'b0;
        o_write_reg  = r_instr[25:21];
        o_done       = 1'b0;
        o_illegal    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_instr_valid) begin
                    w_next_state = w_in_legal ? S_ADDR : S_ERR;
                end
            end
            S_ADDR: begin
                o_alu_op     = 4'b0010;
                w_next_state = S_MEM;
            end
            S_MEM: begin
                o_alu_op    = 4'b0010;
                o_mem_write = w_is_store;
                o_mem_read  = !w_is_store;
                if (w_mem_last) begin
`ifdef LS_UPDATE_FORM_EN
                    if (!w_is_store)   w_next_state = S_WB;
                    else if (w_is_upd) w_next_state = S_UPD;
                    else               w_next_state = S_DONE;
`else
                    w_next_state = w_is_store ? S_DONE : S_WB;
`endif
                end
            end
            S_WB: begin
                o_reg_write  = 1'b1;
`ifdef LS_UPDATE_FORM_EN
                w_next_state = w_is_upd ? S_UPD : S_DONE;
`else
                w_next_state = S_DONE;
`endif
            end
`ifdef LS_UPDATE_FORM_EN
            S_UPD: begin
                // Base register takes the effective address from the ALU.
                o_alu_op     = 4'b0010;
                o_reg_write  = 1'b1;
                o_write_reg  = r_instr[20:16];
                o_wb_sel     = 1'b1;
                w_next_state = S_DONE;
            end
`endif
            S_DONE: begin
                o_done       = 1'b1;
                w_next_state = S_IDLE;
            end
            S_ERR: begin
                o_illegal    = 1'b1;
                w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_ls_sequencer.sv
// Scoreboard bench for ls_sequencer: per-instruction expectations queued at accept, checked when done/illegal fires.
module tb_ls_sequencer;

    localparam int LAT = 3;
    localparam int CW  = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          vld;
    logic [31:0]   ins;
    logic          rdy, reg_wr, mem_rd, mem_wr, wb_sel, busy, done, ill;
    logic [3:0]    alu_op;
    logic [4:0]    rr1, rr2, wr_reg;
    logic [31:0]   imm;
    logic [CW-1:0] retired;

    ls_sequencer #(.MEM_LAT(LAT), .CNT_W(CW)) u_dut (
        .i_clk(clk), .i_rst(rst), .i_instr_valid(vld), .i_instr(ins),
        .o_instr_ready(rdy), .o_alu_op(alu_op), .o_read_reg_1(rr1), .o_read_reg_2(rr2),
        .o_write_reg(wr_reg), .o_immediate(imm), .o_reg_write(reg_wr), .o_mem_read(mem_rd),
        .o_mem_write(mem_wr), .o_wb_sel(wb_sel), .o_busy(busy), .o_done(done),
        .o_illegal(ill), .o_retired(retired)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    endtask

    typedef struct {
        bit            ill;
        int            lat;
        int            n_wr, n_rd, n_rw, n_alu;
        logic [5:0]    rw_first, rw_last;
        logic [CW-1:0] ret;
        logic [4:0]    ra, rs;
        logic [31:0]   imm;
    } exp_t;

    exp_t q[$];

    function automatic exp_t model(input logic [31:0] x, input logic [CW-1:0] ret_now);
        exp_t e;
        logic [5:0] op;
        logic [4:0] ra, rt;
        bit st, ld, su, lu;
        op = x[31:26]; rt = x[25:21]; ra = x[20:16];
        st = (op == 6'd36); ld = (op == 6'd32); su = 0; lu = 0;
`ifdef LS_UPDATE_FORM_EN
        su = (op == 6'd37) && (ra != 0);
        lu = (op == 6'd33) && (ra != 0) && (ra != rt);
`endif
        e.ra = ra; e.rs = rt; e.imm = {{16{x[15]}}, x[15:0]};
        e.rw_first = '0; e.rw_last = '0;
        if (!(st || ld || su || lu)) begin
            e.ill = 1; e.lat = 1; e.n_wr = 0; e.n_rd = 0; e.n_rw = 0; e.n_alu = 0; e.ret = ret_now;
        end else begin
            e.ill      = 0;
            e.lat      = 2 + LAT + ((ld || lu) ? 1 : 0) + ((su || lu) ? 1 : 0);
            e.n_wr     = (st || su) ? LAT : 0;
            e.n_rd     = (ld || lu) ? LAT : 0;
            e.n_rw     = ((ld || lu) ? 1 : 0) + ((su || lu) ? 1 : 0);
            e.n_alu    = 1 + LAT + ((su || lu) ? 1 : 0);
            e.rw_first = (ld || lu) ? {1'b0, rt} : {1'b1, ra};
            e.rw_last  = (su || lu) ? {1'b1, ra} : {1'b0, rt};
            e.ret      = ret_now + 1'b1;
        end
        return e;
    endfunction

    int            cyc = 0;
    int            acc_cyc, c_wr, c_rd, c_rw, c_alu;
    logic [5:0]    rw_first, rw_last;
    logic [CW-1:0] model_ret = '0;
    bit            ret_chk = 0;
    logic [CW-1:0] ret_exp;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        #1;
        if (ret_chk) begin
            chk("retired", 32'(retired), 32'(ret_exp));
            ret_chk = 0;
        end
        if (rst) begin
            q.delete();
            model_ret = '0;
        end else begin
            if (mem_wr || mem_rd || reg_wr)
                chk("strobe_excl", 32'(mem_wr) + 32'(mem_rd) + 32'(reg_wr), 1);
            if (q.size() > 0) begin
                if (cyc == acc_cyc) begin
                    chk("read_reg_1", 32'(rr1), 32'(q[0].ra));
                    chk("read_reg_2", 32'(rr2), 32'(q[0].rs));
                    chk("immediate", imm, q[0].imm);
                end
                if (mem_wr) c_wr++;
                if (mem_rd) c_rd++;
                if (alu_op == 4'b0010) c_alu++;
                else if (alu_op != 4'b0000) chk("alu_op_val", 32'(alu_op), 0);
                if (reg_wr) begin
                    if (c_rw == 0) rw_first = {wb_sel, wr_reg};
                    rw_last = {wb_sel, wr_reg};
                    c_rw++;
                end
                if (done || ill) begin
                    exp_t e;
                    e = q.pop_front();
                    chk("illegal_pulse", 32'(ill), 32'(e.ill));
                    chk("done_pulse", 32'(done), 32'(!e.ill));
                    chk("latency", cyc - acc_cyc + 1, e.lat);
                    chk("mem_write_cycles", c_wr, e.n_wr);
                    chk("mem_read_cycles", c_rd, e.n_rd);
                    chk("reg_write_cycles", c_rw, e.n_rw);
                    chk("alu_add_cycles", c_alu, e.n_alu);
                    chk("ready_at_end", 32'(rdy), 0);
                    if (e.n_rw > 0) begin
                        chk("wb_first", 32'(rw_first), 32'(e.rw_first));
                        chk("wb_last", 32'(rw_last), 32'(e.rw_last));
                    end
                    if (!e.ill) begin
                        ret_chk = 1;
                        ret_exp = e.ret;
                    end
                end
            end else begin
                if (done || ill) chk("spurious_end", {30'd0, done, ill}, 0);
                if (mem_wr || mem_rd || reg_wr) chk("idle_strobe", {29'd0, mem_wr, mem_rd, reg_wr}, 0);
            end
            if (vld && rdy) begin
                exp_t e;
                e = model(ins, model_ret);
                if (!e.ill) model_ret = model_ret + 1'b1;
                q.push_back(e);
                acc_cyc = cyc + 1;
                c_wr = 0; c_rd = 0; c_rw = 0; c_alu = 0;
                rw_first = '0; rw_last = '0;
            end
        end
    end

    // Leaves vld high after the accept edge so callers can chain instructions.
    task automatic send(input logic [31:0] x);
        bit ok;
        @(negedge clk);
        vld = 1'b1;
        ins = x;
        ok  = 0;
        for (int i = 0; i < 64 && !ok; i++) begin
            if (rdy) ok = 1;
            @(negedge clk);
        end
        if (!ok) chk("accept_timeout", 32'(rdy), 1);
    endtask

    task automatic drain();
        bit ok;
        vld = 1'b0;
        ok  = 0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (q.size() == 0 && rdy) ok = 1;
        end
        if (!ok) chk("drain_timeout", q.size(), 0);
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; vld = 1'b0; ins = '0;
        repeat (2) @(negedge clk);
        vld = 1'b1; ins = 32'h90240002;
        repeat (2) @(negedge clk);
        vld = 1'b0; rst = 1'b0;
        chk("rst_ready", 32'(rdy), 1);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_retired", 32'(retired), 0);
        chk("rst_alu_op", 32'(alu_op), 0);
        chk("rst_strobes", {29'd0, reg_wr, mem_rd, mem_wr}, 0);
        chk("rst_pulses", {30'd0, done, ill}, 0);
        chk("rst_latch", 32'(rr1), 0);

        send(32'h90240002); drain();           // stw R1,2(R4)
        send(32'h80A2FFFC); drain();           // lwz R5,-4(R2)
        send(32'h7C000000); drain();           // opcode 31
        send(32'h90240002); send(32'h80A2FFFC); drain();
        send(32'h94240008); drain();           // stwu R1,8(R4)
        send(32'h84A20004); drain();           // lwzu R5,4(R2)
        send(32'h84420004); drain();           // lwzu with RA==RT
        send(32'h94200008); drain();           // stwu with RA==0
        for (int i = 0; i < 9; i++) send(32'h90000010 | (32'(i) << 16));
        drain();

        send(32'h90240002);
        vld = 1'b0;
        for (int i = 0; i < 20 && !mem_wr; i++) @(negedge clk);
        chk("mem_seen_before_rst", 32'(mem_wr), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_mem_write", 32'(mem_wr), 0);
        chk("abort_retired", 32'(retired), 0);
        chk("abort_ready", 32'(rdy), 1);
        chk("abort_done", 32'(done), 0);
        repeat (8) @(negedge clk);
        chk("abort_retired_late", 32'(retired), 0);
        send(32'h80A2FFFC); drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
